// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host driver: geometry, command codes and FSM states.
package lcd_pkg;

  localparam int unsigned IMG_W   = 12;
  localparam int unsigned IMG_H   = 9;
  localparam int unsigned IMG_PIX = IMG_W * IMG_H;
  localparam int unsigned WIN_PIX = 16;
  localparam int unsigned TIMEOUT = 255;

  typedef enum logic [2:0] {
    CmdLoadData  = 3'd0,
    CmdZoomIn    = 3'd1,
    CmdZoomFit   = 3'd2,
    CmdRight     = 3'd3,
    CmdLeft      = 3'd4,
    CmdUp        = 3'd5,
    CmdDown      = 3'd6,
    CmdReflash   = 3'd7
  } lcd_cmd_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StLoad    = 3'd2,
    StCollect = 3'd3,
    StFinish  = 3'd4
  } lcd_state_e;

endpackage

// File: rtl/lcd_win_buf.sv
// 16x8 window buffer: one synchronous write port, one combinational read port, no reset.
module lcd_win_buf
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [WIN_PIX];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_host_drv.sv
// Host-side LCD command driver: issues one command per request, streams the image on LOAD
// and captures the 16-beat window returned by the controller.
module lcd_host_drv
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_cmd,
  output logic       req_ready,
  output logic       img_ren,
  output logic [6:0] img_addr,
  input  logic [7:0] img_rdata,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] datain,
  input  logic       busy,
  input  logic [7:0] dataout,
  input  logic       output_valid,
  input  logic [3:0] win_raddr,
  output logic [7:0] win_rdata,
  output logic       win_valid,
  output logic       done,
  output logic       timeout_err
);

  lcd_state_e state_q;
  logic [2:0] cmd_q;
  logic       cmd_valid_q;
  logic       img_ren_q;
  logic [6:0] img_addr_q;
  logic [6:0] pix_cnt_q;
  logic [4:0] beat_cnt_q;
  logic [7:0] to_cnt_q;
  logic       done_q;
  logic       win_valid_q;
  logic       timeout_err_q;

  logic accept;
  logic beat_wr;
  logic beat_last;
  logic timed;
  logic to_hit;
  logic abort;

  // Accepting only while the controller is idle keeps cmd_valid from ever overlapping busy.
  assign req_ready = (state_q == StIdle) && !busy;
  assign accept    = req_valid && req_ready;
  assign beat_wr   = output_valid && (state_q != StIdle) && (beat_cnt_q < 5'(WIN_PIX));
  assign beat_last = beat_wr && (beat_cnt_q == 5'(WIN_PIX - 1));
  assign timed     = (state_q == StLoad) || (state_q == StCollect) || (state_q == StFinish);
  assign to_hit    = !output_valid && (to_cnt_q == 8'(TIMEOUT - 1));
  assign abort     = to_hit && ((state_q == StLoad) || (state_q == StCollect) ||
                                ((state_q == StFinish) && busy));

  assign datain      = (state_q == StLoad) ? img_rdata : 8'd0;
  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign img_ren     = img_ren_q;
  assign img_addr    = img_addr_q;
  assign done        = done_q;
  assign win_valid   = win_valid_q;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      cmd_q         <= 3'd0;
      cmd_valid_q   <= 1'b0;
      img_ren_q     <= 1'b0;
      img_addr_q    <= 7'd0;
      pix_cnt_q     <= 7'd0;
      beat_cnt_q    <= 5'd0;
      to_cnt_q      <= 8'd0;
      done_q        <= 1'b0;
      win_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (beat_wr) begin
        beat_cnt_q <= beat_cnt_q + 5'd1;
      end
      if (output_valid) begin
        to_cnt_q <= 8'd0;
      end else if (timed) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q       <= StIssue;
            cmd_q         <= req_cmd;
            cmd_valid_q   <= 1'b1;
            win_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            beat_cnt_q    <= 5'd0;
            if (req_cmd == CmdLoadData) begin
              img_ren_q  <= 1'b1;
              img_addr_q <= 7'd0;
            end
          end
        end
        StIssue: begin
          to_cnt_q  <= 8'd0;
          pix_cnt_q <= 7'd0;
          if (cmd_q == CmdLoadData) begin
            state_q    <= StLoad;
            img_addr_q <= 7'd1;
          end else begin
            state_q <= StCollect;
          end
        end
        StLoad: begin
          // Read address runs one cycle ahead of the pixel being forwarded on datain.
          if (img_ren_q) begin
            if (img_addr_q == 7'(IMG_PIX - 1)) begin
              img_ren_q  <= 1'b0;
              img_addr_q <= 7'd0;
            end else begin
              img_addr_q <= img_addr_q + 7'd1;
            end
          end
          if (pix_cnt_q == 7'(IMG_PIX - 1)) begin
            state_q  <= StCollect;
            to_cnt_q <= 8'd0;
          end else begin
            pix_cnt_q <= pix_cnt_q + 7'd1;
          end
        end
        StCollect: begin
          if (beat_last || (beat_cnt_q == 5'(WIN_PIX))) begin
            state_q  <= StFinish;
            to_cnt_q <= 8'd0;
          end
        end
        StFinish: begin
          if (!busy) begin
            state_q     <= StIdle;
            done_q      <= 1'b1;
            win_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (abort) begin
        state_q       <= StIdle;
        timeout_err_q <= 1'b1;
        win_valid_q   <= 1'b0;
        done_q        <= 1'b0;
        img_ren_q     <= 1'b0;
        img_addr_q    <= 7'd0;
      end
    end
  end

  lcd_win_buf u_win_buf (
    .clk_i   (clk),
    .we_i    (beat_wr),
    .waddr_i (beat_cnt_q[3:0]),
    .wdata_i (dataout),
    .raddr_i (win_raddr),
    .rdata_o (win_rdata)
  );

endmodule

// File: tb/tb_lcd_host_drv.sv
// Directed bench for lcd_host_drv with a behavioural LCD controller and ramp image memory.
module tb_lcd_host_drv;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_cmd = 3'd0;
  logic       req_ready;
  logic       img_ren;
  logic [6:0] img_addr;
  logic [7:0] img_rdata = 8'd0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy = 1'b0;
  logic [7:0] dataout = 8'd0;
  logic       output_valid = 1'b0;
  logic [3:0] win_raddr = 4'd0;
  logic [7:0] win_rdata;
  logic       win_valid;
  logic       done;
  logic       timeout_err;

  always #5 clk = ~clk;

  lcd_host_drv dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_ready    (req_ready),
    .img_ren      (img_ren),
    .img_addr     (img_addr),
    .img_rdata    (img_rdata),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .datain       (datain),
    .busy         (busy),
    .dataout      (dataout),
    .output_valid (output_valid),
    .win_raddr    (win_raddr),
    .win_rdata    (win_rdata),
    .win_valid    (win_valid),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  // Synchronous-read image memory holding a ramp.
  logic [7:0] mem [108];
  always @(posedge clk) if (img_ren) img_rdata <= mem[img_addr];

  logic [7:0] fit_exp   [16] = '{8'd13, 8'd16, 8'd19, 8'd22, 8'd37, 8'd40, 8'd43, 8'd46,
                                 8'd61, 8'd64, 8'd67, 8'd70, 8'd85, 8'd88, 8'd91, 8'd94};
  logic [7:0] zoom_exp  [16] = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd52, 8'd53, 8'd54, 8'd55,
                                 8'd64, 8'd65, 8'd66, 8'd67, 8'd76, 8'd77, 8'd78, 8'd79};
  logic [7:0] right_exp [16] = '{8'd44, 8'd45, 8'd46, 8'd47, 8'd56, 8'd57, 8'd58, 8'd59,
                                 8'd68, 8'd69, 8'd70, 8'd71, 8'd80, 8'd81, 8'd82, 8'd83};

  // Behavioural LCD controller.
  logic [7:0] m_img [108];
  logic [7:0] m_win [16];
  int m_ph = 0, m_pk = 0, m_gap = 0, m_bk = 0, m_tl = 0, m_r = 3, m_c = 4;
  bit m_zoom = 1'b0, m_withhold = 1'b0, m_extra = 1'b0, m_prev_cv = 1'b0;
  int m_inj_req = 0, m_inj_ack = 0;
  int n_cmd = 0, n_done = 0, n_viol = 0;

  function automatic void m_compute();
    for (int i = 0; i < 16; i++) begin
      int r, c;
      r = m_zoom ? m_r + i / 4 : 1 + 2 * (i / 4);
      c = m_zoom ? m_c + i % 4 : 1 + 3 * (i % 4);
      m_win[i] = m_img[r * 12 + c];
    end
  endfunction

  function automatic void m_apply(input logic [2:0] c);
    case (c)
      3'd0: m_zoom = 1'b0;
      3'd1: if (!m_zoom) begin m_zoom = 1'b1; m_r = 3; m_c = 4; end
      3'd2: m_zoom = 1'b0;
      3'd3: if (m_zoom && m_c < 8) m_c++;
      3'd4: if (m_zoom && m_c > 0) m_c--;
      3'd5: if (m_zoom && m_r > 0) m_r--;
      3'd6: if (m_zoom && m_r < 5) m_r++;
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) n_done++;
    if (cmd_valid) begin
      n_cmd++;
      if (busy || m_prev_cv) n_viol++;
    end
    m_prev_cv = cmd_valid;
    output_valid = 1'b0;
    dataout = 8'd0;
    if (!reset) begin
      m_ph = 0;
      busy = 1'b0;
    end else if (m_inj_req != m_inj_ack && m_ph == 0) begin
      output_valid = 1'b1;
      dataout = 8'hAA;
      m_inj_ack = m_inj_req;
    end else if (cmd_valid) begin
      if (!m_withhold) begin
        busy = 1'b1;
        m_apply(cmd);
        if (cmd == 3'd0) begin
          m_ph = 1; m_pk = 0;
        end else begin
          m_compute(); m_ph = 2; m_gap = 3;
        end
      end
    end else begin
      case (m_ph)
        1: begin
          m_img[m_pk] = datain;
          m_pk++;
          if (m_pk == 108) begin m_compute(); m_ph = 2; m_gap = 3; end
        end
        2: begin
          m_gap--;
          if (m_gap == 0) begin m_ph = 3; m_bk = 0; end
        end
        3: begin
          if (m_bk < (m_extra ? 18 : 16)) begin
            output_valid = 1'b1;
            dataout = (m_bk < 16) ? m_win[m_bk] : 8'hEE;
            m_bk++;
          end else begin
            m_ph = 4; m_tl = 2;
          end
        end
        4: begin
          m_tl--;
          if (m_tl == 0) begin busy = 1'b0; m_ph = 0; end
        end
        default: ;
      endcase
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c);
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd = c;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 600) begin
      step();
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic check_win(input string tag, input logic [7:0] exp [16]);
    for (int i = 0; i < 16; i++) begin
      win_raddr = 4'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), win_rdata, exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_addr, bad_pix, n, d0, c0;
    for (int k = 0; k < 108; k++) mem[k] = 8'(k);

    reset = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {cmd_valid, cmd, datain, img_ren, img_addr, done, win_valid,
                          timeout_err}, 0);
    chk("reset_req_ready", req_ready, 1);
    @(negedge clk) reset = 1'b1;

    // LOAD with ramp image
    issue(3'd0);
    chk("load_cmd_strobe", {cmd_valid, cmd}, {1'b1, 3'd0});
    chk("load_req_ready_low", req_ready, 0);
    bad_addr = 0;
    bad_pix = 0;
    for (int k = 0; k < 108; k++) begin
      if (!(img_ren && img_addr == 7'(k))) bad_addr++;
      if (k > 0 && datain != 8'(k - 1)) bad_pix++;
      step();
      if (k == 0) chk("load_strobe_one_cycle", cmd_valid, 0);
    end
    chk("load_last_pixel", datain, 107);
    chk("load_ren_off", img_ren, 0);
    chk("load_addr_seq_errs", bad_addr, 0);
    chk("load_pix_seq_errs", bad_pix, 0);
    step();
    chk("datain_zero_after_load", datain, 0);
    wait_done("load_done");
    chk("load_win_valid", win_valid, 1);
    step();
    chk("done_one_cycle", done, 0);
    check_win("load_win", fit_exp);

    // ZOOM_IN
    issue(3'd1);
    chk("zoom_cmd", {cmd_valid, cmd, img_ren}, {1'b1, 3'd1, 1'b0});
    chk("zoom_win_valid_cleared", win_valid, 0);
    step();
    chk("zoom_strobe_one_cycle", cmd_valid, 0);
    wait_done("zoom_done");
    check_win("zoom_win", zoom_exp);

    // SHIFT_RIGHT x5, column clamps at 8
    d0 = n_done;
    for (int i = 0; i < 5; i++) begin
      issue(3'd3);
      wait_done("right_done");
    end
    step();
    chk("right_done_pulses", n_done - d0, 5);
    check_win("right_win", right_exp);

    // REFLASH with two surplus beats that must not land in the buffer
    m_extra = 1'b1;
    issue(3'd7);
    wait_done("extra_done");
    m_extra = 1'b0;
    check_win("extra_win", right_exp);

    // output_valid while IDLE leaves the buffer untouched
    m_inj_req++;
    repeat (3) step();
    win_raddr = 4'd0;
    #1;
    chk("idle_beat_ignored", win_rdata, 44);
    chk("idle_win_valid_kept", win_valid, 1);

    // Controller withholds the window
    m_withhold = 1'b1;
    d0 = n_done;
    issue(3'd2);
    n = 0;
    while (!timeout_err && n < 400) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, 256);
    chk("timeout_req_ready", req_ready, 1);
    chk("timeout_win_valid", win_valid, 0);
    step();
    chk("timeout_no_done", n_done - d0, 0);
    chk("timeout_sticky", timeout_err, 1);
    m_withhold = 1'b0;
    issue(3'd2);
    chk("timeout_err_cleared", timeout_err, 0);
    wait_done("fit_done");
    check_win("fit_win", fit_exp);

    // Reset in the middle of a LOAD
    issue(3'd0);
    repeat (51) step();
    chk("pre_reset_pixel", datain, 50);
    @(negedge clk) reset = 1'b0;
    repeat (2) step();
    chk("midreset_outputs", {cmd_valid, cmd, datain, img_ren, img_addr, done, win_valid,
                             timeout_err}, 0);
    @(negedge clk) reset = 1'b1;
    step();
    chk("midreset_req_ready", req_ready, 1);
    issue(3'd0);
    wait_done("reload_done");
    chk("reload_win_valid", win_valid, 1);
    check_win("reload_win", fit_exp);

    // req_valid held high continuously
    c0 = n_cmd;
    d0 = n_done;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd = 3'd7;
    repeat (100) step();
    @(negedge clk) req_valid = 1'b0;
    repeat (60) step();
    chk("hold_cmd_eq_done", n_cmd - c0, n_done - d0);
    chk("hold_multiple_cmds", (n_cmd - c0) >= 3, 1);
    chk("cmd_valid_vs_busy_violations", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
